// File: rtl/fifo_byte_packer.sv
// Pops bytes from the async_fifo read port and packs them little-endian into LANES-lane words.
// A level flush emits any partial word together with its valid-lane count.
module fifo_byte_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4
) (
  input  logic                          read_clk,
  input  logic                          read_reset_n,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_read_data,
  output logic                          fifo_read_en,
  input  logic                          flush,
  output logic [DATA_WIDTH*LANES-1:0]   word_data,
  output logic [$clog2(LANES):0]        word_bytes,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          busy
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = LANE_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;
  localparam int unsigned WORD_W = DATA_WIDTH * LANES;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LANES);

  logic [CNT_W-1:0]                   r_fill;
  logic                               r_rd_pend;
  logic [LANES-1:0][DATA_WIDTH-1:0]   r_pack;
  logic [WORD_W-1:0]                  r_word_data;
  logic [CNT_W-1:0]                   r_word_bytes;
  logic                               r_word_valid;

  logic                               w_out_free;
  logic                               w_xfer;
  logic                               w_flush_xfer;
  logic                               w_load;
  logic [CNT_W-1:0]                   w_fill_eff;
  logic [OCC_W-1:0]                   w_occupancy;
  logic [LANE_W-1:0]                  w_lane;
  logic [WORD_W-1:0]                  w_out_word;

  // Transfer decisions and pop gating; a full pack draining this edge frees room for a new pop
  always_comb begin
    w_out_free   = !r_word_valid || word_ready;
    w_xfer       = (r_fill == FULL) && w_out_free;
    w_flush_xfer = flush && !r_rd_pend && (r_fill != '0) && (r_fill < FULL) && w_out_free;
    w_load       = w_xfer || w_flush_xfer;
    w_fill_eff   = w_xfer ? '0 : r_fill;
    w_occupancy  = OCC_W'(w_fill_eff) + OCC_W'(r_rd_pend);
    w_lane       = LANE_W'(w_fill_eff);
    fifo_read_en = read_reset_n && !fifo_empty && !flush && (w_occupancy < OCC_W'(LANES));
  end

  // Filled lanes pass through, unfilled lanes read as zero
  always_comb begin
    w_out_word = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (CNT_W'(i) < r_fill) begin
        w_out_word[i*DATA_WIDTH +: DATA_WIDTH] = r_pack[i];
      end
    end
  end

  // Pack register: the byte of a pop accepted last cycle lands at the effective fill lane
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      r_fill    <= '0;
      r_rd_pend <= 1'b0;
      r_pack    <= '0;
    end else begin
      r_rd_pend <= fifo_read_en;
      if (r_rd_pend) begin
        r_pack[w_lane] <= fifo_read_data;
        r_fill         <= w_fill_eff + CNT_W'(1);
      end else if (w_load) begin
        r_fill <= '0;
      end
    end
  end

  // Output register: loads on a full or flush transfer, drops valid once accepted
  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      r_word_data  <= '0;
      r_word_bytes <= '0;
      r_word_valid <= 1'b0;
    end else if (w_load) begin
      r_word_data  <= w_out_word;
      r_word_bytes <= w_xfer ? FULL : r_fill;
      r_word_valid <= 1'b1;
    end else if (word_ready) begin
      r_word_valid <= 1'b0;
    end
  end

  assign word_data  = r_word_data;
  assign word_bytes = r_word_bytes;
  assign word_valid = r_word_valid;
  assign busy       = (r_fill != '0) || r_rd_pend || r_word_valid;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a 1-cycle-latency FIFO read-port model.
module tb_fifo_byte_packer;

  logic        read_clk = 1'b0;
  logic        read_reset_n;
  logic        fifo_empty;
  logic [7:0]  fifo_read_data = 8'h00;
  logic        fifo_read_en;
  logic        flush;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;
  logic        busy;

  logic [7:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pops   = 0;
  logic        en_hist [$];
  logic [31:0] words_q [$];
  logic [2:0]  bytes_q [$];

  int total = 0;
  int bad   = 0;

  fifo_byte_packer #(.DATA_WIDTH(8), .LANES(4)) dut (
    .read_clk       (read_clk),
    .read_reset_n   (read_reset_n),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .flush          (flush),
    .word_data      (word_data),
    .word_bytes     (word_bytes),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .busy           (busy)
  );

  always #5 read_clk = ~read_clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read port model plus an accepted-word collector
  always @(posedge read_clk) begin
    en_hist.push_back(fifo_read_en);
    if (fifo_read_en) begin
      fifo_read_data <= mem[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
      pops           <= pops + 1;
    end
    if (read_reset_n && word_valid && word_ready) begin
      words_q.push_back(word_data);
      bytes_q.push_back(word_bytes);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_words(input int n, input int budget, output int cycles);
    cycles = 0;
    while (words_q.size() < n && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("word_wait", 32'(words_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int p0;
    int cyc;
    int hb;
    int mism;

    read_reset_n = 1'b1;
    flush        = 1'b0;
    word_ready   = 1'b1;
    #1 read_reset_n = 1'b0;

    // Reset state, with data waiting in the FIFO
    for (int k = 0; k < 8; k++) push(8'(k * 17));
    repeat (2) tick();
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_bytes", 32'(word_bytes), 32'd0);
    chk("rst_data", word_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rden", 32'(fifo_read_en), 32'd0);

    // Basic fill: two full words
    read_reset_n = 1'b1;
    base = words_q.size();
    wait_words(base + 2, 40, cyc);
    chk("basic_w0", words_q[base], 32'h33221100);
    chk("basic_b0", 32'(bytes_q[base]), 32'd4);
    chk("basic_w1", words_q[base+1], 32'h77665544);
    chk("basic_b1", 32'(bytes_q[base+1]), 32'd4);
    wait_idle(10);

    // Backpressure: one word held, one full pack, then popping stops
    word_ready = 1'b0;
    base = words_q.size();
    p0   = pops;
    for (int k = 0; k < 12; k++) push(8'(8'h20 + k));
    repeat (15) tick();
    chk("bp_pops", 32'(pops - p0), 32'd8);
    chk("bp_rden", 32'(fifo_read_en), 32'd0);
    chk("bp_valid", 32'(word_valid), 32'd1);
    chk("bp_data", word_data, 32'h23222120);
    chk("bp_bytes", 32'(word_bytes), 32'd4);
    repeat (3) tick();
    chk("bp_hold", word_data, 32'h23222120);
    word_ready = 1'b1;
    wait_words(base + 3, 30, cyc);
    chk("bp_w0", words_q[base], 32'h23222120);
    chk("bp_w1", words_q[base+1], 32'h27262524);
    chk("bp_w2", words_q[base+2], 32'h2B2A2928);
    wait_idle(10);

    // Partial flush of three bytes
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (6) tick();
    chk("pf_novalid", 32'(word_valid), 32'd0);
    chk("pf_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    chk("pf_valid", 32'(word_valid), 32'd1);
    chk("pf_data", word_data, 32'h00CCBBAA);
    chk("pf_bytes", 32'(word_bytes), 32'd3);
    chk("pf_busy_hi", 32'(busy), 32'd1);
    tick();
    chk("pf_valid_lo", 32'(word_valid), 32'd0);
    chk("pf_busy_lo", 32'(busy), 32'd0);

    // Flush with an empty packer: nothing happens, no pops
    push(8'h55);
    #1;
    chk("fe_rden", 32'(fifo_read_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fe_valid", 32'(word_valid), 32'd0);
      chk("fe_busy", 32'(busy), 32'd0);
    end

    // Flush rising right after a pop is accepted: in-flight byte is included
    flush = 1'b0;
    #1;
    chk("fp_rden", 32'(fifo_read_en), 32'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("fp_rden_off", 32'(fifo_read_en), 32'd0);
    tick();
    chk("fp_wait_capture", 32'(word_valid), 32'd0);
    tick();
    chk("fp_valid", 32'(word_valid), 32'd1);
    chk("fp_data", word_data, 32'h00000055);
    chk("fp_bytes", 32'(word_bytes), 32'd1);
    tick();
    chk("fp_busy_lo", 32'(busy), 32'd0);
    flush = 1'b0;

    // Reset mid-word: two captured, one in flight
    push(8'h01); push(8'h02); push(8'h03);
    repeat (3) tick();
    chk("rm_busy_pre", 32'(busy), 32'd1);
    base = words_q.size();
    read_reset_n = 1'b0;
    #1;
    chk("rm_valid", 32'(word_valid), 32'd0);
    chk("rm_bytes", 32'(word_bytes), 32'd0);
    chk("rm_data", word_data, 32'h0);
    chk("rm_busy", 32'(busy), 32'd0);
    push(8'h04); push(8'h05); push(8'h06); push(8'h07);
    #1;
    chk("rm_rden", 32'(fifo_read_en), 32'd0);
    #3 read_reset_n = 1'b1;
    wait_words(base + 1, 20, cyc);
    chk("rm_word", words_q[base], 32'h07060504);
    chk("rm_wbytes", 32'(bytes_q[base]), 32'd4);
    wait_idle(10);

    // Throughput: 40 bytes streaming, 4-on/1-off popping
    base = words_q.size();
    for (int k = 0; k < 40; k++) push(8'(8'h80 + k));
    hb = en_hist.size();
    wait_words(base + 10, 70, cyc);
    chk("tp_cycles", 32'(cyc < 55), 32'd1);
    for (int j = 0; j < 10; j++) begin
      chk("tp_word", words_q[base+j],
          {8'(8'h80 + 4*j + 3), 8'(8'h80 + 4*j + 2), 8'(8'h80 + 4*j + 1), 8'(8'h80 + 4*j)});
    end
    mism = 0;
    for (int k = 0; k < 50; k++) begin
      if (en_hist[hb+k] !== ((k % 5) != 4)) mism++;
    end
    chk("tp_pop_pattern", 32'(mism), 32'd0);
    wait_idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
